// File: rtl/controller_port.sv
// Two-pad serial controller port: a $4016 strobe write latches both pads, and each
// pad then shifts one button out per completed CPU read of $4016/$4017.
module controller_port #(
  parameter logic [7:0] OPEN_BUS = 8'h40,
  parameter logic       FILL_BIT = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       STROBE_WE,
  input  logic [7:0] CPU_DO,
  input  logic       CONTROL1_EN,
  input  logic       CONTROL2_EN,
  input  logic [7:0] BUTTONS1,
  input  logic [7:0] BUTTONS2,
  output logic [7:0] CONTROL1,
  output logic [7:0] CONTROL2,
  output logic       STROBE
);

  typedef enum logic {
    SHIFT  = 1'b0,
    RELOAD = 1'b1
  } port_state_e;

  port_state_e state1_q, state1_d;
  port_state_e state2_q, state2_d;
  logic [7:0]  sr1_q, sr1_d;
  logic [7:0]  sr2_q, sr2_d;
  logic        en1_q, en1_d;
  logic        en2_q, en2_d;
  logic        load_now;
  logic        read_end1;
  logic        read_end2;
  logic        cpu_do_unused;

  assign cpu_do_unused = ^CPU_DO[7:1];

  // A strobe-set write reloads in its own cycle, so it beats a coincident read-end.
  assign load_now  = STROBE_WE & CPU_DO[0];
  assign read_end1 = en1_q & ~CONTROL1_EN;
  assign read_end2 = en2_q & ~CONTROL2_EN;

  always_comb begin
    state1_d = state1_q;
    state2_d = state2_q;
    if (STROBE_WE) begin
      state1_d = CPU_DO[0] ? RELOAD : SHIFT;
      state2_d = CPU_DO[0] ? RELOAD : SHIFT;
    end

    sr1_d = sr1_q;
    if ((state1_q == RELOAD) || load_now) begin
      sr1_d = BUTTONS1;
    end else if (read_end1) begin
      sr1_d = {FILL_BIT, sr1_q[7:1]};
    end

    sr2_d = sr2_q;
    if ((state2_q == RELOAD) || load_now) begin
      sr2_d = BUTTONS2;
    end else if (read_end2) begin
      sr2_d = {FILL_BIT, sr2_q[7:1]};
    end

    en1_d = CONTROL1_EN;
    en2_d = CONTROL2_EN;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state1_q <= SHIFT;
      state2_q <= SHIFT;
      sr1_q    <= 8'hFF;
      sr2_q    <= 8'hFF;
      en1_q    <= 1'b0;
      en2_q    <= 1'b0;
    end else begin
      state1_q <= state1_d;
      state2_q <= state2_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      en1_q    <= en1_d;
      en2_q    <= en2_d;
    end
  end

  assign CONTROL1 = OPEN_BUS | {7'b0, sr1_q[0]};
  assign CONTROL2 = OPEN_BUS | {7'b0, sr2_q[0]};
  assign STROBE   = (state1_q == RELOAD);

endmodule

// File: tb/tb_controller_port.sv
// Self-checking bench for controller_port: directed scenarios plus a randomized run
// compared against a snapshot-and-read-count model of each pad.
module tb_controller_port;

  logic       Clk;
  logic       Reset;
  logic       STROBE_WE;
  logic [7:0] CPU_DO;
  logic       CONTROL1_EN;
  logic       CONTROL2_EN;
  logic [7:0] BUTTONS1;
  logic [7:0] BUTTONS2;
  logic [7:0] CONTROL1;
  logic [7:0] CONTROL2;
  logic       STROBE;

  int n_checks = 0;
  int n_fail   = 0;

  controller_port dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .STROBE_WE  (STROBE_WE),
    .CPU_DO     (CPU_DO),
    .CONTROL1_EN(CONTROL1_EN),
    .CONTROL2_EN(CONTROL2_EN),
    .BUTTONS1   (BUTTONS1),
    .BUTTONS2   (BUTTONS2),
    .CONTROL1   (CONTROL1),
    .CONTROL2   (CONTROL2),
    .STROBE     (STROBE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: each pad is a button snapshot plus how many reads have completed since it.
  logic [7:0] m_snap1, m_snap2;
  int         m_cnt1, m_cnt2;
  logic       m_stb, m_en1_prev, m_en2_prev;

  function automatic logic [7:0] exp_byte(input logic [7:0] snap, input int cnt);
    return (cnt >= 8) ? 8'h41 : (8'h40 | {7'b0, snap[cnt]});
  endfunction

  task automatic model_reset();
    m_snap1 = 8'hFF; m_snap2 = 8'hFF;
    m_cnt1 = 8; m_cnt2 = 8;
    m_stb = 1'b0; m_en1_prev = 1'b0; m_en2_prev = 1'b0;
  endtask

  task automatic model_step();
    bit reload;
    reload = m_stb || (STROBE_WE && CPU_DO[0]);
    if (reload) begin
      m_snap1 = BUTTONS1; m_cnt1 = 0;
      m_snap2 = BUTTONS2; m_cnt2 = 0;
    end else begin
      if (m_en1_prev && !CONTROL1_EN && m_cnt1 < 8) m_cnt1++;
      if (m_en2_prev && !CONTROL2_EN && m_cnt2 < 8) m_cnt2++;
    end
    if (STROBE_WE) m_stb = CPU_DO[0];
    m_en1_prev = CONTROL1_EN;
    m_en2_prev = CONTROL2_EN;
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    STROBE_WE = 1'b0; CPU_DO = 8'h00; CONTROL1_EN = 1'b0; CONTROL2_EN = 1'b0;
  endtask

  task automatic latch(input logic [7:0] b1, input logic [7:0] b2);
    BUTTONS1 = b1; BUTTONS2 = b2;
    STROBE_WE = 1'b1; CPU_DO = 8'h01; tick();
    CPU_DO = 8'h00; tick();
    idle();
  endtask

  task automatic do_read(input int port, input int len, output logic [7:0] val, output bit stable);
    logic [7:0] s;
    stable = 1'b1;
    val = 8'h00;
    if (port == 1) CONTROL1_EN = 1'b1; else CONTROL2_EN = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      s = (port == 1) ? CONTROL1 : CONTROL2;
      if (i == 0) val = s;
      else if (s !== val) stable = 1'b0;
    end
    CONTROL1_EN = 1'b0; CONTROL2_EN = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; idle(); BUTTONS1 = 8'h00; BUTTONS2 = 8'h00;
    model_reset();
    #2;
    n_checks++;
    if (CONTROL1 !== 8'h41) begin n_fail++; $display("[TB] FAIL reset_control1 got %h want 41", CONTROL1); end
    n_checks++;
    if (CONTROL2 !== 8'h41) begin n_fail++; $display("[TB] FAIL reset_control2 got %h want 41", CONTROL2); end
    n_checks++;
    if (STROBE !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobe got %b want 0", STROBE); end
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_read_sequence();
    logic [7:0] exp [10] = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h41, 8'h41, 8'h41};
    logic [7:0] v;
    bit st;
    latch(8'b1010_0101, 8'h00);
    for (int i = 0; i < 10; i++) begin
      do_read(1, 1, v, st);
      n_checks++;
      if (v !== exp[i]) begin n_fail++; $display("[TB] FAIL read_seq[%0d] got %h want %h", i, v, exp[i]); end
    end
  endtask

  task automatic test_reload_tracking();
    logic [7:0] v;
    bit st;
    BUTTONS1 = 8'h00; STROBE_WE = 1'b1; CPU_DO = 8'h01; tick(); idle();
    for (int i = 0; i < 6; i++) begin
      BUTTONS1 = {7'b0, 1'(i & 1)};
      tick();
      n_checks++;
      if (CONTROL1 !== (8'h40 | BUTTONS1)) begin
        n_fail++; $display("[TB] FAIL track[%0d] got %h want %h", i, CONTROL1, 8'h40 | BUTTONS1);
      end
    end
    BUTTONS1 = 8'h01;
    for (int i = 0; i < 3; i++) begin
      do_read(1, 1, v, st);
      n_checks++;
      if (v !== 8'h41) begin n_fail++; $display("[TB] FAIL reload_read[%0d] got %h want 41", i, v); end
    end
    n_checks++;
    if (STROBE !== 1'b1) begin n_fail++; $display("[TB] FAIL reload_strobe got %b want 1", STROBE); end
    STROBE_WE = 1'b1; CPU_DO = 8'h00; tick(); idle();
  endtask

  task automatic test_long_read();
    logic [7:0] exp [9] = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
    logic [7:0] v;
    bit st;
    latch(8'h00, 8'h81);
    for (int i = 0; i < 9; i++) begin
      do_read(2, 4, v, st);
      n_checks++;
      if (v !== exp[i]) begin n_fail++; $display("[TB] FAIL long_read[%0d] got %h want %h", i, v, exp[i]); end
      n_checks++;
      if (st !== 1'b1) begin n_fail++; $display("[TB] FAIL long_stable[%0d] got %b want 1", i, st); end
    end
  endtask

  task automatic test_independent();
    logic [7:0] v;
    bit st;
    latch(8'hA5, 8'h5A);
    for (int i = 0; i < 3; i++) do_read(1, 1, v, st);
    do_read(2, 2, v, st);
    n_checks++;
    if (CONTROL1 !== 8'h40) begin n_fail++; $display("[TB] FAIL indep_port1 got %h want 40", CONTROL1); end
    n_checks++;
    if (CONTROL2 !== 8'h41) begin n_fail++; $display("[TB] FAIL indep_port2 got %h want 41", CONTROL2); end
  endtask

  task automatic test_reload_wins();
    logic [7:0] v;
    bit st;
    latch(8'h00, 8'h00);
    do_read(1, 1, v, st);
    BUTTONS1 = 8'hC3;
    CONTROL1_EN = 1'b1; tick();
    CONTROL1_EN = 1'b0; STROBE_WE = 1'b1; CPU_DO = 8'h01; tick();
    n_checks++;
    if (CONTROL1 !== 8'h41) begin n_fail++; $display("[TB] FAIL reload_wins got %h want 41", CONTROL1); end
    n_checks++;
    if (STROBE !== 1'b1) begin n_fail++; $display("[TB] FAIL reload_wins_strobe got %b want 1", STROBE); end
    CPU_DO = 8'h00; tick(); idle();
    for (int i = 0; i < 8; i++) begin
      do_read(1, 1, v, st);
      n_checks++;
      if (v !== (8'h40 | {7'b0, BUTTONS1[i]})) begin
        n_fail++; $display("[TB] FAIL reload_wins_bit[%0d] got %h want %h", i, v, 8'h40 | {7'b0, BUTTONS1[i]});
      end
    end
  endtask

  task automatic test_clear_collision();
    logic [7:0] v;
    bit st;
    BUTTONS1 = 8'h5A; STROBE_WE = 1'b1; CPU_DO = 8'h01; tick(); idle();
    CONTROL1_EN = 1'b1; tick();
    CONTROL1_EN = 1'b0; STROBE_WE = 1'b1; CPU_DO = 8'h00; BUTTONS1 = 8'h36; tick(); idle();
    for (int i = 0; i < 4; i++) begin
      do_read(1, 1, v, st);
      n_checks++;
      if (v !== (8'h40 | {7'b0, BUTTONS1[i]})) begin
        n_fail++; $display("[TB] FAIL clear_collision[%0d] got %h want %h", i, v, 8'h40 | {7'b0, BUTTONS1[i]});
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    bit st;
    latch(8'h00, 8'h00);
    for (int i = 0; i < 4; i++) do_read(1, 1, v, st);
    CONTROL1_EN = 1'b1; STROBE_WE = 1'b1; CPU_DO = 8'h01; tick();
    STROBE_WE = 1'b0; CPU_DO = 8'h00;
    n_checks++;
    if (STROBE !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_strobe got %b want 1", STROBE); end
    #2 Reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (CONTROL1 !== 8'h41) begin n_fail++; $display("[TB] FAIL async_reset_control1 got %h want 41", CONTROL1); end
    n_checks++;
    if (STROBE !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_strobe got %b want 0", STROBE); end
    @(posedge Clk); #1;
    Reset = 1'b0; idle();
    latch(8'hA5, 8'h00);
    do_read(1, 1, v, st);
    n_checks++;
    if (v !== 8'h41) begin n_fail++; $display("[TB] FAIL post_reset_read0 got %h want 41", v); end
    do_read(1, 1, v, st);
    n_checks++;
    if (v !== 8'h40) begin n_fail++; $display("[TB] FAIL post_reset_read1 got %h want 40", v); end
  endtask

  task automatic test_random();
    logic [7:0] e1, e2;
    for (int i = 0; i < 400; i++) begin
      STROBE_WE = ($urandom_range(0, 11) == 0);
      CPU_DO = 8'($urandom);
      if ($urandom_range(0, 2) == 0) CONTROL1_EN = ~CONTROL1_EN;
      if ($urandom_range(0, 2) == 0) CONTROL2_EN = ~CONTROL2_EN;
      BUTTONS1 = 8'($urandom);
      BUTTONS2 = 8'($urandom);
      tick();
      e1 = exp_byte(m_snap1, m_cnt1);
      e2 = exp_byte(m_snap2, m_cnt2);
      n_checks++;
      if (CONTROL1 !== e1) begin n_fail++; $display("[TB] FAIL rand_control1[%0d] got %h want %h", i, CONTROL1, e1); end
      n_checks++;
      if (CONTROL2 !== e2) begin n_fail++; $display("[TB] FAIL rand_control2[%0d] got %h want %h", i, CONTROL2, e2); end
      n_checks++;
      if (STROBE !== m_stb) begin n_fail++; $display("[TB] FAIL rand_strobe[%0d] got %b want %b", i, STROBE, m_stb); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_read_sequence();
    test_reload_tracking();
    test_long_read();
    test_independent();
    test_reload_wins();
    test_clear_collision();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
